// File: rtl/mux_2x1_rr_arbiter_if.sv
// Requester/downstream bundle for the 2:1 round-robin arbiter.
// master drives the requests and downstream ready; slave is the arbiter.
interface mux_2x1_rr_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             req0;
   logic [WIDTH-1:0] i0;
   logic             last0;
   logic             req1;
   logic [WIDTH-1:0] i1;
   logic             last1;
   logic             out_ready;
   logic             gnt0;
   logic             gnt1;
   logic             s0;
   logic [WIDTH-1:0] y;
   logic             out_valid;

   modport master (
      output req0, i0, last0, req1, i1, last1, out_ready,
      input  gnt0, gnt1, s0, y, out_valid
   );

   modport slave (
      input  req0, i0, last0, req1, i1, last1, out_ready,
      output gnt0, gnt1, s0, y, out_valid
   );
endinterface

// File: rtl/mux_2x1_rr_arbiter.sv
// Packet-aware 2:1 round-robin arbiter driving a shared data mux.
// A grant is held until the owner's LAST beat or MAX_BEATS accepted beats.
module mux_2x1_rr_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BEATS = 16
) (
   input logic                   clk,
   input logic                   rst,
   mux_2x1_rr_arbiter_if.slave   bus
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             gnt0_q;
   logic             gnt1_q;
   logic             s0_q;
   logic             pri_q;
   logic [CNT_W-1:0] cnt_q;

   logic             gnt0_d;
   logic             gnt1_d;
   logic             s0_d;
   logic             pri_d;
   logic [CNT_W-1:0] cnt_d;

   logic             out_valid_c;
   logic             accept_c;
   logic             own_last_c;
   logic             release_c;
   logic [WIDTH-1:0] y_mux;

   // Handshake qualifiers shared by next-state and output logic
   always_comb begin
      out_valid_c = (gnt0_q & bus.req0) | (gnt1_q & bus.req1);
      accept_c    = out_valid_c & bus.out_ready;
      own_last_c  = gnt1_q ? bus.last1 : bus.last0;
      release_c   = accept_c & (own_last_c | (cnt_q == LAST_CNT));
      y_mux       = s0_q ? bus.i1 : bus.i0;
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         s0_q    <= 1'b0;
         pri_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         s0_q    <= s0_d;
         pri_q   <= pri_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: on release, the other requester is the only criterion
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.req0 && bus.req1) begin
               state_d = pri_q ? OWN1 : OWN0;
            end else if (bus.req0) begin
               state_d = OWN0;
            end else if (bus.req1) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            if (release_c) begin
               state_d = bus.req1 ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (release_c) begin
               state_d = bus.req0 ? OWN0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of registered outputs, priority pointer and beat counter
   always_comb begin
      gnt0_d = (state_d == OWN0);
      gnt1_d = (state_d == OWN1);
      s0_d   = s0_q;
      pri_d  = pri_q;
      cnt_d  = cnt_q;
      if (state_d == OWN1) begin
         s0_d = 1'b1;
      end else if (state_d == OWN0) begin
         s0_d = 1'b0;
      end
      if (state_d != state_q) begin
         cnt_d = '0;
         if (state_d == OWN0) begin
            pri_d = 1'b1;
         end else if (state_d == OWN1) begin
            pri_d = 1'b0;
         end
      end else if (accept_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.s0        = s0_q;
   assign bus.out_valid = out_valid_c;
   assign bus.y         = y_mux;

   a_excl_gnt: assert property (@(posedge clk) disable iff (rst)
      !(gnt0_q && gnt1_q));

   a_gnt_state: assert property (@(posedge clk) disable iff (rst)
      (gnt0_q == (state_q == OWN0)) && (gnt1_q == (state_q == OWN1)));

   a_cnt_range: assert property (@(posedge clk) disable iff (rst)
      cnt_q <= LAST_CNT);

endmodule

// File: doc/mux_2x1_rr_arbiter.md
MUX_2X1_RR_ARBITER -- requirements
Module: mux_2x1_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester and of the output channel.
REQ-002 Parameter MAX_BEATS, default 16: maximum accepted beats per grant before forced release; legal range 1..255.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 REQ0  input  1  requester 0 has a beat pending.
REQ-006 I0  input  WIDTH  requester 0 data.
REQ-007 LAST0  input  1  requester 0 current beat ends its packet.
REQ-008 REQ1  input  1  requester 1 has a beat pending.
REQ-009 I1  input  WIDTH  requester 1 data.
REQ-010 LAST1  input  1  requester 1 current beat ends its packet.
REQ-011 OUT_READY  input  1  downstream accepts the beat this cycle.
REQ-012 GNT0  output  1  requester 0 owns the shared 2:1 data mux.
REQ-013 GNT1  output  1  requester 1 owns the shared 2:1 data mux.
REQ-014 S0  output  1  mux select: 1 selects I1, 0 selects I0.
REQ-015 Y  output  WIDTH  muxed data, combinational: S0 ? I1 : I0.
REQ-016 OUT_VALID  output  1  beat on Y is valid.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, OWN0, OWN1.
REQ-018 GNT0 SHALL be 1 only in OWN0 and GNT1 only in OWN1; never both 1.
REQ-019 S0 SHALL be a registered output: 1 in OWN1, 0 in OWN0, holding its last value in IDLE.
REQ-020 OUT_VALID SHALL equal (GNT0 & REQ0) | (GNT1 & REQ1).
REQ-021 A beat SHALL be accepted in any cycle where OUT_VALID & OUT_READY = 1.
REQ-022 IDLE -> OWN0/OWN1 SHALL occur one cycle after a request is sampled; no grant is issued combinationally.
REQ-023 From IDLE with one request, that requester SHALL be granted.
REQ-024 From IDLE with both requests, the requester not served most recently SHALL be granted (register PRI; PRI=0 after reset, i.e. requester 0 wins first).
REQ-025 Ownership SHALL persist until release: an accepted beat with the owner's LAST=1, or the MAX_BEATS-th accepted beat of the grant.
REQ-026 On release, if the other requester's REQ is 1 in the same cycle, the FSM SHALL move directly OWNx -> OWN(other) with no IDLE cycle; otherwise to IDLE.
REQ-027 On release, the other requester's REQ SHALL be the only criterion; the releasing owner is never re-granted directly if the other is requesting.
REQ-028 On release to IDLE while only the releasing owner still requests, the FSM SHALL pass through IDLE for one cycle, then re-grant it.
REQ-029 PRI SHALL update on every entry into OWNx to point at the other requester.
REQ-030 An 8-bit beat counter SHALL count accepted beats within a grant, clearing on every grant change and on entry to IDLE.
REQ-031 Owner deasserting REQ mid-packet SHALL NOT release the grant; OUT_VALID falls to 0, state holds.
REQ-032 OUT_READY=0 SHALL stall: no counter increment, no release, state holds.
REQ-033 Requests from the non-owner SHALL be ignored until release.

Reset
REQ-034 While RST=1: state=IDLE, GNT0=0, GNT1=0, S0=0, OUT_VALID=0, PRI=0, beat counter=0, independent of CLK.
REQ-035 RST asserted mid-packet SHALL abort the grant immediately; after deassertion arbitration restarts from IDLE with requester 0 prioritised.

Verification
REQ-036 Reset: RST=1 with REQ0=REQ1=1 -> GNT0=GNT1=0, OUT_VALID=0, S0=0; first edge after RST=0 -> GNT0=1.
REQ-037 Alternation: both requesting 1-beat packets (LAST=1), OUT_READY=1 -> grants alternate 0,1,0,1 each cycle with no IDLE gap; Y=I0,I1,I0,I1.
REQ-038 Packet lock: REQ0 3-beat packet (A,B,C, LAST on C), REQ1 asserted at beat 1 -> Y=A,B,C then I1 data; GNT1 one cycle after C accepted.
REQ-039 Stall: OUT_READY=0 for 4 cycles mid-packet -> Y, S0, GNT stable; no beat lost or duplicated.
REQ-040 Forced release: MAX_BEATS=4, REQ0 streams LAST=0, REQ1=1 -> GNT0 drops after 4th accepted beat, GNT1=1 next cycle.
REQ-041 Mid-packet async reset: RST pulsed between clock edges during OWN1 -> GNT1=0 and OUT_VALID=0 before next edge; then requester 0 wins a tie.
